// File: rtl/physics_sweep_scheduler.sv
// Paces the shared force/integration datapath across all objects: holds each
// object index for a settle window, then strobes a one-cycle commit.
module physics_sweep_scheduler #(
    parameter int unsigned NUM_OBJECTS   = 8,
    parameter int unsigned SEL_W         = 3,
    parameter int unsigned SETTLE_CYCLES = 31,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               frame_tick,
    input  logic               step,
    input  logic               clear_overrun,
    output logic [SEL_W-1:0]   object_select,
    output logic               commit,
    output logic               busy,
    output logic               sweep_done,
    output logic               overrun,
    output logic [COUNT_W-1:0] sweep_count
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_OBJECTS - 1);

    logic [1:0]         state_q,   state_d;
    logic [SEL_W-1:0]   sel_q,     sel_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               commit_q,  commit_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               overrun_q, overrun_d;
    logic [COUNT_W-1:0] count_q,   count_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            commit_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            commit_q  <= commit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        commit_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        count_d   = count_q;

        // A tick during any busy cycle is dropped and flagged; set beats clear.
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end
        if (frame_tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if ((run && frame_tick) || step) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d  = ST_COMMIT;
                    commit_d = 1'b1;
                    done_d   = (sel_q == SEL_LAST);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                if (sel_q == SEL_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sel_d   = '0;
                    count_d = count_q + COUNT_W'(1);
                end else begin
                    state_d = ST_SETTLE;
                    sel_d   = sel_q + SEL_W'(1);
                    cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sel_d   = '0;
            end
        endcase
    end

    assign object_select = sel_q;
    assign commit        = commit_q;
    assign busy          = busy_q;
    assign sweep_done    = done_q;
    assign overrun       = overrun_q;
    assign sweep_count   = count_q;

endmodule
